// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB strobes.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to park in a TRAP state on an illegal instruction.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [5:0]  alu_ctrl,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  input  logic        alu_zero,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        branch_taken,
  output logic        done,
  output logic        illegal
);

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] SRC_B_RT   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    K_RTYPE, K_LW, K_SW, K_BEQ, K_ADDI, K_ILLEGAL
  } kind_t;

  state_t      state, state_next;
  kind_t       kind;
  logic [31:0] instr_q;
  logic        done_q, done_next;
  logic        illegal_q, illegal_next;

  // Register/immediate fields are consumed by the datapath, not by this controller.
  logic unused_fields;
  assign unused_fields = ^instr_q[25:6];

  // Instruction class is derived from the latched word so every output stays Moore.
  always_comb begin
    kind = K_ILLEGAL;
    case (instr_q[31:26])
      OP_RTYPE: begin
        if (instr_q[5:0] == ALU_ADD || instr_q[5:0] == ALU_SUB ||
            instr_q[5:0] == ALU_AND || instr_q[5:0] == ALU_OR)
          kind = K_RTYPE;
      end
      OP_LW:   kind = K_LW;
      OP_SW:   kind = K_SW;
      OP_BEQ:  kind = K_BEQ;
      OP_ADDI: kind = K_ADDI;
      default: kind = K_ILLEGAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      instr_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_next;
      done_q    <= done_next;
      illegal_q <= illegal_next;
      if (state == S_IDLE && instr_valid)
        instr_q <= instr;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_next   = state;
    done_next    = 1'b0;
    illegal_next = 1'b0;
    case (state)
      S_IDLE:   if (instr_valid) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (kind == K_ILLEGAL) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          state_next   = S_TRAP;
`else
          state_next   = S_IDLE;
          illegal_next = 1'b1;
`endif
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (kind)
          K_RTYPE, K_ADDI: state_next = S_WB;
          K_LW, K_SW:      state_next = S_MEM;
          default: begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (kind == K_LW) begin
          state_next = S_WB;
        end else begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      S_WB: begin
        state_next = S_IDLE;
        done_next  = 1'b1;
      end
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready   = 1'b0;
    alu_ctrl      = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_RT;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    done          = 1'b0;
    illegal       = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        done        = done_q;
        illegal     = illegal_q;
      end
      S_FETCH: begin
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
        mem_read  = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (kind)
          K_RTYPE: alu_ctrl = instr_q[5:0];
          K_LW, K_SW, K_ADDI: alu_src_b = SRC_B_IMM;
          K_BEQ: begin
            alu_ctrl      = ALU_SUB;
            pc_write_cond = 1'b1;
          end
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      S_MEM: begin
        mem_read  = (kind == K_LW);
        mem_write = (kind == K_SW);
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (kind == K_RTYPE);
        mem_to_reg = (kind == K_LW);
      end
      S_TRAP:  illegal = 1'b1;
      default: instr_ready = 1'b0;
    endcase
  end

  // The only Mealy path: branch decision follows the ALU flag within the EXEC cycle.
  assign branch_taken = pc_write_cond & alu_zero;

  a_done_illegal_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(done && illegal));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors for each instruction class.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0;
  logic        instr_ready, alu_src_a, pc_write, pc_write_cond, mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg, branch_taken, done, illegal;
  logic [5:0]  alu_ctrl;
  logic [1:0]  alu_src_b;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_zero(alu_zero), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .branch_taken(branch_taken), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {ready, alu_ctrl, src_a, src_b, pc_write, pc_write_cond, mem_read, mem_write,
  //  reg_write, reg_dst, mem_to_reg, done, illegal}
  logic [18:0] obs;
  assign obs = {instr_ready, alu_ctrl, alu_src_a, alu_src_b, pc_write, pc_write_cond,
                mem_read, mem_write, reg_write, reg_dst, mem_to_reg, done, illegal};

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;

  localparam logic [18:0] IDL    = {1'b1, ADD, 1'b0, 2'b00, 7'b0000000, 2'b00};
  localparam logic [18:0] IDD    = {1'b1, ADD, 1'b0, 2'b00, 7'b0000000, 2'b10};
  localparam logic [18:0] IDI    = {1'b1, ADD, 1'b0, 2'b00, 7'b0000000, 2'b01};
  localparam logic [18:0] FET    = {1'b0, ADD, 1'b0, 2'b01, 7'b1010000, 2'b00};
  localparam logic [18:0] DEC    = {1'b0, ADD, 1'b0, 2'b00, 7'b0000000, 2'b00};
  localparam logic [18:0] EX_I   = {1'b0, ADD, 1'b1, 2'b10, 7'b0000000, 2'b00};
  localparam logic [18:0] EX_B   = {1'b0, SUB, 1'b1, 2'b00, 7'b0100000, 2'b00};
  localparam logic [18:0] MEM_LW = {1'b0, ADD, 1'b0, 2'b00, 7'b0010000, 2'b00};
  localparam logic [18:0] MEM_SW = {1'b0, ADD, 1'b0, 2'b00, 7'b0001000, 2'b00};
  localparam logic [18:0] WB_R   = {1'b0, ADD, 1'b0, 2'b00, 7'b0000110, 2'b00};
  localparam logic [18:0] WB_I   = {1'b0, ADD, 1'b0, 2'b00, 7'b0000100, 2'b00};
  localparam logic [18:0] WB_LW  = {1'b0, ADD, 1'b0, 2'b00, 7'b0000101, 2'b00};
  localparam logic [18:0] TRP    = {1'b0, ADD, 1'b0, 2'b00, 7'b0000000, 2'b01};

  function automatic logic [18:0] ex_r(input logic [5:0] f);
    return {1'b0, f, 1'b1, 2'b00, 7'b0000000, 2'b00};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== IDL) begin
      errors++;
      $display("FAIL reset_hold: got %b want %b", obs, IDL);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== IDL) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", obs, IDL);
    end
  endtask

  task automatic test_add();
    logic [18:0] e [6];
    e = '{FET, DEC, ex_r(ADD), WB_R, IDD, IDL};
    instr = 32'h00221820;
    instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) instr_valid = 1'b0;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL add cycle %0d: got %b want %b", i + 1, obs, e[i]);
      end
    end
  endtask

  task automatic test_addi();
    logic [18:0] e [6];
    e = '{FET, DEC, EX_I, WB_I, IDD, IDL};
    instr = 32'h20220005;
    instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) instr_valid = 1'b0;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL addi cycle %0d: got %b want %b", i + 1, obs, e[i]);
      end
    end
  endtask

  task automatic test_beq(input logic zero);
    logic [18:0] e [5];
    logic        bt_exp;
    e = '{FET, DEC, EX_B, IDD, IDL};
    alu_zero = zero;
    instr = 32'h10220003;
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) instr_valid = 1'b0;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL beq(z=%0b) cycle %0d: got %b want %b", zero, i + 1, obs, e[i]);
      end
      bt_exp = (i == 2) && zero;
      checks++;
      if (branch_taken !== bt_exp) begin
        errors++;
        $display("FAIL branch_taken(z=%0b) cycle %0d: got %b want %b", zero, i + 1,
                 branch_taken, bt_exp);
      end
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_lw();
    logic [18:0] e [7];
    e = '{FET, DEC, EX_I, MEM_LW, WB_LW, IDD, IDL};
    instr = 32'h8C220004;
    instr_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) instr_valid = 1'b0;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL lw cycle %0d: got %b want %b", i + 1, obs, e[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [18:0] e [6];
    e = '{FET, DEC, EX_I, MEM_SW, IDD, IDL};
    instr = 32'hAC220004;
    instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) instr_valid = 1'b0;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL sw cycle %0d: got %b want %b", i + 1, obs, e[i]);
      end
    end
  endtask

  task automatic test_illegal(input logic [31:0] word);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic [18:0] e [6];
    e = '{FET, DEC, TRP, TRP, TRP, TRP};
`else
    logic [18:0] e [4];
    e = '{FET, DEC, IDI, IDL};
`endif
    instr = word;
    instr_valid = 1'b1;
    for (int i = 0; i < $size(e); i++) begin
      step();
      if (i == 0) instr_valid = 1'b0;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL illegal %h cycle %0d: got %b want %b", word, i + 1, obs, e[i]);
      end
    end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    test_reset();
`endif
  endtask

  task automatic test_reset_mid_lw();
    logic [18:0] e [3];
    e = '{FET, DEC, EX_I};
    instr = 32'h8C220004;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) instr_valid = 1'b0;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL lw_pre_reset cycle %0d: got %b want %b", i + 1, obs, e[i]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== IDL) begin
      errors++;
      $display("FAIL reset_mid_exec: got %b want %b", obs, IDL);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== IDL) begin
        errors++;
        $display("FAIL post_abort cycle %0d: got %b want %b", i + 1, obs, IDL);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    logic [5:0]  fn [3];
    logic [18:0] e [5];
    words = '{32'h00221822, 32'h00221824, 32'h00221825};
    fn    = '{SUB, AND, OR};
    instr = words[0];
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = '{FET, DEC, ex_r(fn[k]), WB_R, IDD};
      for (int i = 0; i < 5; i++) begin
        step();
        // Changing instr mid-flight must not disturb the latched word.
        if (i == 0 && k < 2) instr = words[k + 1];
        if (i == 4 && k == 2) instr_valid = 1'b0;
        checks++;
        if (obs !== e[i]) begin
          errors++;
          $display("FAIL b2b instr %0d cycle %0d: got %b want %b", k, i + 1, obs, e[i]);
        end
      end
    end
    step();
    checks++;
    if (obs !== IDL) begin
      errors++;
      $display("FAIL b2b idle: got %b want %b", obs, IDL);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_beq(1'b1);
    test_beq(1'b0);
    test_lw();
    test_sw();
    test_illegal(32'hFC000000);
    test_illegal(32'h00221821);
    test_reset_mid_lw();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: instr_valid  in  1  instruction word offered; instr  in  32  MIPS instruction word.
REQ-004 SHALL have: instr_ready  out  1  controller can accept an instruction.
REQ-005 SHALL have: alu_ctrl  out  6  ALU operation code: 100000 add, 100010 sub, 100100 and, 100101 or.
REQ-006 SHALL have: alu_src_a  out  1  (0 = PC, 1 = rs); alu_src_b  out  2  (00 = rt, 01 = constant 4, 10 = sign-extended imm16).
REQ-007 SHALL have: alu_zero  in  1  ALU zero flag from the current operation.
REQ-008 SHALL have: pc_write, pc_write_cond, mem_read, mem_write, reg_write, reg_dst, mem_to_reg  out  1 each, datapath strobes.
REQ-009 SHALL have: branch_taken  out  1  (= pc_write_cond AND alu_zero, combinational); done  out  1; illegal  out  1.

Function
REQ-010 SHALL implement a Moore FSM with states IDLE, FETCH, DECODE, EXEC, MEM, WB; all outputs except branch_taken SHALL be functions of state and latched instruction only.
REQ-011 SHALL drive instr_ready = 1 only in IDLE; transfer occurs when instr_valid AND instr_ready on a rising edge; instr SHALL be latched into an internal register and FSM SHALL move to FETCH.
REQ-012 SHALL ignore instr and instr_valid outside IDLE; instr_valid held high SHALL be accepted again on the first cycle back in IDLE.
REQ-013 FETCH: alu_src_a = 0, alu_src_b = 01, alu_ctrl = 100000, pc_write = 1, mem_read = 1; next DECODE.
REQ-014 DECODE: no strobes; decode opcode instr[31:26] and funct instr[5:0]; supported: R-type (opcode 000000, funct 100000/100010/100100/100101), lw 100011, sw 101011, beq 000100, addi 001000; next EXEC, or IDLE with illegal pulse for anything else.
REQ-015 EXEC: alu_src_a = 1; R-type alu_src_b = 00, alu_ctrl = funct; lw/sw/addi alu_src_b = 10, alu_ctrl = 100000; beq alu_src_b = 00, alu_ctrl = 100010, pc_write_cond = 1.
REQ-016 After EXEC: R-type/addi -> WB; lw/sw -> MEM; beq -> IDLE with done.
REQ-017 MEM: lw mem_read = 1 -> WB; sw mem_write = 1 -> IDLE with done.
REQ-018 WB: reg_write = 1; reg_dst = 1 for R-type, 0 otherwise; mem_to_reg = 1 for lw only; -> IDLE with done.
REQ-019 Cycles from accept edge to done: beq 3, R-type 4, addi 4, sw 4, lw 5; illegal pulse 2 cycles after accept.
REQ-020 done and illegal SHALL be single-cycle pulses asserted in the first IDLE cycle after completion; never both high.
REQ-021 In states where alu_ctrl is not specified it SHALL be 100000 and alu_src_b 00.

Reset
REQ-022 rst_n low SHALL force IDLE immediately regardless of clk, abort any instruction without done, and clear the latched instruction.
REQ-023 During and after reset until first accept: instr_ready = 1, alu_ctrl = 100000, all other outputs 0.

Configuration
REQ-024 Macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: when defined, an illegal instruction SHALL enter a TRAP state holding illegal = 1 and instr_ready = 0 until rst_n asserts; when undefined, behaviour is REQ-014/REQ-020 (one-cycle pulse, return to IDLE).

Verification
REQ-025 Reset: rst_n low mid-EXEC of lw -> next observation IDLE, instr_ready = 1, all strobes 0, no done.
REQ-026 add $3,$1,$2 (0x00221820) accepted -> FETCH add/src_b 01/pc_write, EXEC alu_ctrl 100000 src_b 00, WB reg_write reg_dst = 1, done 4 cycles after accept.
REQ-027 beq with alu_zero = 1 in EXEC -> branch_taken = 1 that cycle, done 3 cycles after accept; alu_zero = 0 -> branch_taken = 0.
REQ-028 lw (0x8C220004) -> MEM mem_read = 1, WB mem_to_reg = 1 reg_dst = 0, done at 5 cycles; sw (0xAC220004) -> mem_write = 1, no reg_write, done at 4.
REQ-029 Opcode 0x3F -> illegal pulse 2 cycles after accept, no reg_write/mem_write; with MULTICYCLE_CTRL_ILLEGAL_TRAP_EN illegal stays 1, instr_ready 0 until reset.
REQ-030 instr_valid held high across back-to-back sub/and/or -> each accepted on the cycle done pulses, alu_ctrl in EXEC = 100010, 100100, 100101 respectively.
